counter_sequencer: RTL and testbench

//  Run-control FSM for the enable-driven counter/register datapath.

---
 rtl/counter_sequencer.sv | 97 +++++++++
 tb/tb_counter_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run-control sequencer: issues exactly lim_q one-cycle increment enables at a
// prescaled rate, with pause (hold), abort (stop) and done signalling.
module counter_sequencer #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic [PW-1:0] divisor,
  input  logic [W-1:0]  limit,
  output logic          cnt_en,
  output logic [W-1:0]  issued,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] r_divQ;
  logic [W-1:0]  r_limQ;
  logic [W-1:0]  r_issued;
  logic          r_cntEn;

  logic          w_launch;
  logic          w_tick;
  logic [W-1:0]  w_issuedNext;

  assign w_launch     = start && !stop && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_tick       = (r_pre == r_divQ);
  assign w_issuedNext = r_issued + 1'b1;

  // Leaving PAUSE with hold low also advances the prescaler, so a pause costs
  // exactly as many cycles as hold was sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pre    <= '0;
      r_divQ   <= '0;
      r_limQ   <= '0;
      r_issued <= '0;
      r_cntEn  <= 1'b0;
    end else begin
      r_cntEn <= 1'b0;
      if (w_launch) begin
        r_divQ   <= divisor;
        r_limQ   <= limit;
        r_issued <= '0;
        r_pre    <= '0;
        r_state  <= (limit == '0) ? S_DONE : S_RUN;
      end else begin
        case (r_state)
          S_RUN, S_PAUSE: begin
            if (stop) begin
              r_state <= S_IDLE;
            end else if (hold) begin
              r_state <= S_PAUSE;
            end else begin
              r_state <= S_RUN;
              if (w_tick) begin
                r_cntEn  <= 1'b1;
                r_pre    <= '0;
                r_issued <= w_issuedNext;
                if (w_issuedNext == r_limQ) begin
                  r_state <= S_DONE;
                end
              end else begin
                r_pre <= r_pre + 1'b1;
              end
            end
          end
          S_DONE: begin
            if (stop) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_en = r_cntEn;
  assign issued = r_issued;
  assign busy   = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random stimulus, all
// checked every cycle against a progress-count reference model.
module tb_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic [3:0] divisor;
  logic [7:0] limit;
  logic       cnt_en;
  logic [7:0] issued;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  int cycleCount;
  int attachedCount;
  int pulseCycles[$];

  // Reference model: a run is a count of productive cycles; a pulse lands on
  // every multiple of div+1 and issued is simply that count divided by div+1.
  int mMode;
  int mDiv;
  int mLim;
  int mProg;
  int mIssued;
  int mEn;

  counter_sequencer #(.W(8), .PW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .divisor (divisor),
    .limit   (limit),
    .cnt_en  (cnt_en),
    .issued  (issued),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic hd,
                               input logic [3:0] dv, input logic [7:0] lm);
    start   = st;
    stop    = sp;
    hold    = hd;
    divisor = dv;
    limit   = lm;
  endtask

  task automatic modelReset();
    mMode   = 0;
    mDiv    = 0;
    mLim    = 0;
    mProg   = 0;
    mIssued = 0;
    mEn     = 0;
  endtask

  task automatic modelLaunch();
    mDiv    = int'(divisor);
    mLim    = int'(limit);
    mProg   = 0;
    mIssued = 0;
    mMode   = (mLim == 0) ? 2 : 1;
  endtask

  // Mode 0 = idle, 1 = busy (running or paused), 2 = done.
  task automatic modelEdge();
    mEn = 0;
    case (mMode)
      0: if (start && !stop) modelLaunch();
      1: begin
        if (stop) begin
          mMode = 0;
        end else if (!hold) begin
          mProg++;
          if (mProg % (mDiv + 1) == 0) begin
            mEn     = 1;
            mIssued = mProg / (mDiv + 1);
            if (mIssued == mLim) mMode = 2;
          end
        end
      end
      default: begin
        if (stop) mMode = 0;
        else if (start) modelLaunch();
      end
    endcase
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    cycleCount++;
    if (cnt_en) begin
      attachedCount++;
      pulseCycles.push_back(cycleCount);
    end
    checkOutput("cnt_en", 32'(cnt_en), 32'(mEn));
    checkOutput("issued", 32'(issued), 32'(mIssued));
    checkOutput("busy", 32'(busy), 32'(mMode == 1));
    checkOutput("done", 32'(done), 32'(mMode == 2));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic clearTrace();
    attachedCount = 0;
    pulseCycles.delete();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cycleCount = 0;
    clearTrace();
    modelReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 4'd0, 8'd0);
    #12;
    checkOutput("reset_cnt_en", 32'(cnt_en), 0);
    checkOutput("reset_issued", 32'(issued), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: div=2, lim=3, pulses three cycles apart, done with the third.
    clearTrace();
    applyStimulus(1, 0, 0, 4'd2, 8'd3);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd2, 8'd3);
    runCycles(9);
    checkOutput("s1_pulses", 32'(attachedCount), 3);
    checkOutput("s1_done_with_last", 32'(done && cnt_en), 1);
    checkOutput("s1_first_latency", 32'(pulseCycles.size() > 0 ? pulseCycles[0] - (cycleCount - 9) : 0), 3);
    runCycles(2);

    // Scenario 2: div=0, lim=5, back-to-back pulses into an attached counter.
    clearTrace();
    applyStimulus(1, 0, 0, 4'd0, 8'd5);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd0, 8'd5);
    runCycles(6);
    checkOutput("s2_counter", 32'(attachedCount), 5);
    checkOutput("s2_done", 32'(done), 1);

    // Scenario 3: lim=0 goes straight to done with no pulses.
    clearTrace();
    applyStimulus(1, 0, 0, 4'd1, 8'd0);
    stepCycle();
    checkOutput("s3_done", 32'(done), 1);
    applyStimulus(0, 0, 0, 4'd1, 8'd0);
    runCycles(3);
    checkOutput("s3_pulses", 32'(attachedCount), 0);

    // Scenario 4: div=3, lim=4, hold for 7 cycles after the second pulse.
    applyStimulus(0, 1, 0, 4'd0, 8'd0);
    stepCycle();
    clearTrace();
    applyStimulus(1, 0, 0, 4'd3, 8'd4);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd3, 8'd4);
    runCycles(8);
    applyStimulus(0, 0, 1, 4'd3, 8'd4);
    runCycles(7);
    applyStimulus(0, 0, 0, 4'd3, 8'd4);
    runCycles(12);
    checkOutput("s4_pulses", 32'(attachedCount), 4);
    checkOutput("s4_gap", 32'(pulseCycles.size() >= 3 ? pulseCycles[2] - pulseCycles[1] : 0), 11);
    checkOutput("s4_done", 32'(done), 1);

    // Scenario 5: stop lands on a tick edge; start and divisor changes mid-run ignored.
    clearTrace();
    applyStimulus(1, 0, 0, 4'd3, 8'd4);
    stepCycle();
    applyStimulus(1, 0, 0, 4'd0, 8'd9);
    runCycles(7);
    checkOutput("s5_one_pulse", 32'(attachedCount), 1);
    applyStimulus(0, 1, 0, 4'd0, 8'd9);
    stepCycle();
    checkOutput("s5_stop_no_pulse", 32'(cnt_en), 0);
    checkOutput("s5_issued", 32'(issued), 1);
    applyStimulus(0, 0, 0, 4'd0, 8'd9);
    runCycles(3);
    checkOutput("s5_retained", 32'(issued), 1);

    // Scenario 6: asynchronous reset while cnt_en is high.
    applyStimulus(1, 0, 0, 4'd0, 8'd10);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd0, 8'd10);
    runCycles(3);
    checkOutput("s6_pre_reset_en", 32'(cnt_en), 1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("s6_async_cnt_en", 32'(cnt_en), 0);
    checkOutput("s6_async_issued", 32'(issued), 0);
    checkOutput("s6_async_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runCycles(3);

    // Largest legal limit must complete without wrapping.
    applyStimulus(1, 0, 0, 4'd0, 8'd255);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd0, 8'd255);
    runCycles(257);
    checkOutput("max_issued", 32'(issued), 255);
    checkOutput("max_done", 32'(done), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 5) == 0,
                    (($urandom % 8) == 0) ? 4'(15) : 4'($urandom % 4), 8'($urandom % 6));
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
